// File: rtl/irq_collect.sv
// irq_collect: destination-side interrupt collector.
// Latches one-cycle interrupt pulses into per-source pending bits, keeps
// saturating per-source event counters and overrun flags, and drives a
// single level interrupt to the CPU through an enable mask and a
// moderation holdoff timer.
module irq_collect #(
  parameter int N_SRC     = 8,
  parameter int CNT_W     = 8,
  parameter int HOLDOFF_W = 16,
  localparam int SEL_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     irq_in,
  input  logic                 enable_wr,
  input  logic [N_SRC-1:0]     enable_wdata,
  input  logic                 clear_wr,
  input  logic [N_SRC-1:0]     clear_wdata,
  input  logic                 holdoff_wr,
  input  logic [HOLDOFF_W-1:0] holdoff_wdata,
  input  logic [SEL_W-1:0]     cnt_sel,
  output logic [CNT_W-1:0]     cnt_rdata,
  output logic [N_SRC-1:0]     pending,
  output logic [N_SRC-1:0]     overrun,
  output logic [N_SRC-1:0]     enable,
  output logic                 irq_out
);

  localparam logic [CNT_W-1:0]     CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]     CNT_ONE     = CNT_W'(1);
  localparam logic [HOLDOFF_W-1:0] HOLDOFF_ONE = HOLDOFF_W'(1);
  localparam logic [HOLDOFF_W-1:0] HOLDOFF_ZERO = '0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ASSERT  = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  // Per-source state
  logic [N_SRC-1:0]     pending_q, pending_d;
  logic [N_SRC-1:0]     overrun_q, overrun_d;
  logic [N_SRC-1:0]     enable_q, enable_d;
  logic [CNT_W-1:0]     count_q [N_SRC];
  logic [CNT_W-1:0]     count_d [N_SRC];

  // Configuration and readback
  logic [HOLDOFF_W-1:0] holdoff_len_q, holdoff_len_d;
  logic [CNT_W-1:0]     cnt_rdata_q, cnt_rdata_d;

  // Output interrupt state machine
  state_t               state_q;
  logic [HOLDOFF_W-1:0] timer_q;
  logic                 irq_out_q;

  logic [N_SRC-1:0]     clr_mask;
  logic                 active;

  // Clear strobe qualified into a per-source write-1-to-clear mask
  always_comb begin
    clr_mask = clear_wr ? clear_wdata : '0;
  end

  // Per-source pending/overrun/counter next state; a pulse beats a clear
  // on pending and the counter, but a clear always wins on overrun
  always_comb begin
    pending_d = pending_q;
    overrun_d = overrun_q;
    count_d   = count_q;
    for (int i = 0; i < N_SRC; i++) begin
      pending_d[i] = irq_in[i] | (pending_q[i] & ~clr_mask[i]);
      if (clr_mask[i]) begin
        overrun_d[i] = 1'b0;
        count_d[i]   = irq_in[i] ? CNT_ONE : '0;
      end else begin
        overrun_d[i] = overrun_q[i] | (irq_in[i] & pending_q[i]);
        if (irq_in[i] && (count_q[i] != CNT_MAX)) begin
          count_d[i] = count_q[i] + CNT_ONE;
        end else begin
          count_d[i] = count_q[i];
        end
      end
    end
  end

  // Enable mask and holdoff length register writes
  always_comb begin
    enable_d      = enable_wr ? enable_wdata : enable_q;
    holdoff_len_d = holdoff_wr ? holdoff_wdata : holdoff_len_q;
  end

  // Counter readback mux; selects beyond the last source read as zero
  always_comb begin
    cnt_rdata_d = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cnt_sel == i[SEL_W-1:0]) begin
        cnt_rdata_d = count_q[i];
      end
    end
  end

  // An enabled source with a registered pending bit requests the CPU
  always_comb begin
    active = |(pending_q & enable_q);
  end

  // Registered per-source state, configuration and readback
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q     <= '0;
      overrun_q     <= '0;
      enable_q      <= '0;
      holdoff_len_q <= '0;
      cnt_rdata_q   <= '0;
      for (int i = 0; i < N_SRC; i++) begin
        count_q[i] <= '0;
      end
    end else begin
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      enable_q      <= enable_d;
      holdoff_len_q <= holdoff_len_d;
      cnt_rdata_q   <= cnt_rdata_d;
      for (int i = 0; i < N_SRC; i++) begin
        count_q[i] <= count_d[i];
      end
    end
  end

  // Interrupt moderation FSM; the holdoff length is sampled only when
  // leaving ASSERT, so a write during a running holdoff affects the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      irq_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (active) begin
            state_q   <= S_ASSERT;
            irq_out_q <= 1'b1;
          end else begin
            irq_out_q <= 1'b0;
          end
        end
        S_ASSERT: begin
          if (!active) begin
            irq_out_q <= 1'b0;
            if (holdoff_len_q == HOLDOFF_ZERO) begin
              state_q <= S_IDLE;
            end else begin
              state_q <= S_HOLDOFF;
              timer_q <= holdoff_len_q;
            end
          end else begin
            irq_out_q <= 1'b1;
          end
        end
        S_HOLDOFF: begin
          irq_out_q <= 1'b0;
          timer_q   <= timer_q - HOLDOFF_ONE;
          if (timer_q <= HOLDOFF_ONE) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          irq_out_q <= 1'b0;
        end
      endcase
    end
  end

  assign pending   = pending_q;
  assign overrun   = overrun_q;
  assign enable    = enable_q;
  assign cnt_rdata = cnt_rdata_q;
  assign irq_out   = irq_out_q;

endmodule

// File: tb/tb_irq_collect.sv
// tb_irq_collect: directed self-checking bench for irq_collect.
module tb_irq_collect;

  localparam int N_SRC     = 8;
  localparam int CNT_W     = 8;
  localparam int HOLDOFF_W = 16;

  logic                 clk;
  logic                 rst_n;
  logic [N_SRC-1:0]     irq_in;
  logic                 enable_wr;
  logic [N_SRC-1:0]     enable_wdata;
  logic                 clear_wr;
  logic [N_SRC-1:0]     clear_wdata;
  logic                 holdoff_wr;
  logic [HOLDOFF_W-1:0] holdoff_wdata;
  logic [2:0]           cnt_sel;
  logic [CNT_W-1:0]     cnt_rdata;
  logic [N_SRC-1:0]     pending;
  logic [N_SRC-1:0]     overrun;
  logic [N_SRC-1:0]     enable;
  logic                 irq_out;

  int vectors = 0;
  int errors  = 0;

  irq_collect #(
    .N_SRC(N_SRC),
    .CNT_W(CNT_W),
    .HOLDOFF_W(HOLDOFF_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .irq_in(irq_in),
    .enable_wr(enable_wr),
    .enable_wdata(enable_wdata),
    .clear_wr(clear_wr),
    .clear_wdata(clear_wdata),
    .holdoff_wr(holdoff_wr),
    .holdoff_wdata(holdoff_wdata),
    .cnt_sel(cnt_sel),
    .cnt_rdata(cnt_rdata),
    .pending(pending),
    .overrun(overrun),
    .enable(enable),
    .irq_out(irq_out)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_enable(input logic [N_SRC-1:0] mask);
    enable_wr = 1'b1;
    enable_wdata = mask;
    tick();
    enable_wr = 1'b0;
  endtask

  task automatic do_clear(input logic [N_SRC-1:0] mask);
    clear_wr = 1'b1;
    clear_wdata = mask;
    tick();
    clear_wr = 1'b0;
    clear_wdata = '0;
  endtask

  task automatic do_holdoff(input logic [HOLDOFF_W-1:0] len);
    holdoff_wr = 1'b1;
    holdoff_wdata = len;
    tick();
    holdoff_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({pending, overrun, enable} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_regs: got %h/%h/%h expected 00/00/00", pending, overrun, enable);
    end
    vectors++;
    if ({irq_out, cnt_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_out: irq_out=%b cnt_rdata=%h expected 0/00", irq_out, cnt_rdata);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pulse();
    do_enable(8'h04);
    irq_in = 8'h04;
    tick();
    irq_in = '0;
    vectors++;
    if (pending !== 8'h04 || irq_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_e0: pending=%h irq_out=%b expected 04/0", pending, irq_out);
    end
    cnt_sel = 3'd2;
    tick();
    vectors++;
    if (irq_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_e1: irq_out=%b expected 1", irq_out);
    end
    vectors++;
    if (cnt_rdata !== 8'd1) begin
      errors++;
      $display("[TB] FAIL single_count: got %0d expected 1", cnt_rdata);
    end
    do_clear(8'h04);
    vectors++;
    if (pending !== 8'h00 || irq_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_clr0: pending=%h irq_out=%b expected 00/1", pending, irq_out);
    end
    tick();
    vectors++;
    if (irq_out !== 1'b0 || cnt_rdata !== 8'd0) begin
      errors++;
      $display("[TB] FAIL single_clr1: irq_out=%b count=%0d expected 0/0", irq_out, cnt_rdata);
    end
  endtask

  task automatic test_disabled_source();
    irq_in = 8'h20;
    repeat (3) tick();
    irq_in = '0;
    cnt_sel = 3'd5;
    tick();
    vectors++;
    if (pending !== 8'h20 || overrun !== 8'h20) begin
      errors++;
      $display("[TB] FAIL dis_latch: pending=%h overrun=%h expected 20/20", pending, overrun);
    end
    vectors++;
    if (cnt_rdata !== 8'd3 || irq_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dis_count: count=%0d irq_out=%b expected 3/0", cnt_rdata, irq_out);
    end
    do_enable(8'h20);
    vectors++;
    if (enable !== 8'h20 || irq_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dis_en0: enable=%h irq_out=%b expected 20/0", enable, irq_out);
    end
    tick();
    vectors++;
    if (irq_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dis_en1: irq_out=%b expected 1", irq_out);
    end
    do_clear(8'h20);
    tick();
    vectors++;
    if (irq_out !== 1'b0 || overrun !== 8'h00) begin
      errors++;
      $display("[TB] FAIL dis_clr: irq_out=%b overrun=%h expected 0/00", irq_out, overrun);
    end
  endtask

  task automatic test_clear_collision();
    irq_in = 8'h02;
    repeat (2) tick();
    irq_in = '0;
    vectors++;
    if (overrun !== 8'h02) begin
      errors++;
      $display("[TB] FAIL coll_pre: overrun=%h expected 02", overrun);
    end
    irq_in = 8'h02;
    clear_wr = 1'b1;
    clear_wdata = 8'h02;
    cnt_sel = 3'd1;
    tick();
    irq_in = '0;
    clear_wr = 1'b0;
    clear_wdata = '0;
    vectors++;
    if (pending !== 8'h02 || overrun !== 8'h00) begin
      errors++;
      $display("[TB] FAIL coll_bits: pending=%h overrun=%h expected 02/00", pending, overrun);
    end
    tick();
    vectors++;
    if (cnt_rdata !== 8'd1) begin
      errors++;
      $display("[TB] FAIL coll_count: got %0d expected 1", cnt_rdata);
    end
    do_clear(8'h02);
  endtask

  task automatic test_saturation();
    cnt_sel = 3'd0;
    irq_in = 8'h01;
    repeat (254) tick();
    irq_in = '0;
    tick();
    vectors++;
    if (cnt_rdata !== 8'd254) begin
      errors++;
      $display("[TB] FAIL sat_254: got %0d expected 254", cnt_rdata);
    end
    irq_in = 8'h01;
    repeat (46) tick();
    irq_in = '0;
    tick();
    vectors++;
    if (cnt_rdata !== 8'd255 || overrun !== 8'h01 || irq_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_255: count=%0d overrun=%h irq_out=%b expected 255/01/0", cnt_rdata, overrun, irq_out);
    end
    do_clear(8'h01);
    tick();
    vectors++;
    if (cnt_rdata !== 8'd0) begin
      errors++;
      $display("[TB] FAIL sat_clr: got %0d expected 0", cnt_rdata);
    end
  endtask

  task automatic test_holdoff();
    int low;
    do_holdoff(16'd10);
    do_enable(8'h04);
    irq_in = 8'h04;
    tick();
    irq_in = '0;
    tick();
    vectors++;
    if (irq_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_assert: irq_out=%b expected 1", irq_out);
    end
    // first interval, with a new length written partway through
    do_clear(8'h04);
    irq_in = 8'h04;
    tick();
    irq_in = '0;
    low = 0;
    while (irq_out === 1'b0 && low < 40) begin
      low++;
      if (low == 4) begin
        holdoff_wr = 1'b1;
        holdoff_wdata = 16'd3;
      end
      tick();
      holdoff_wr = 1'b0;
    end
    vectors++;
    if (low != 11 || irq_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_10: low cycles=%0d irq_out=%b expected 11/1", low, irq_out);
    end
    // second interval uses the newly written length
    do_clear(8'h04);
    irq_in = 8'h04;
    tick();
    irq_in = '0;
    low = 0;
    while (irq_out === 1'b0 && low < 40) begin
      low++;
      tick();
    end
    vectors++;
    if (low != 4 || irq_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL hold_3: low cycles=%0d irq_out=%b expected 4/1", low, irq_out);
    end
    do_clear(8'h04);
    repeat (8) tick();
  endtask

  task automatic test_reset_mid();
    int low;
    irq_in = 8'h04;
    tick();
    irq_in = '0;
    cnt_sel = 3'd2;
    tick();
    vectors++;
    if (irq_out !== 1'b1 || cnt_rdata !== 8'd1) begin
      errors++;
      $display("[TB] FAIL rst_pre: irq_out=%b count=%0d expected 1/1", irq_out, cnt_rdata);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({pending, overrun, enable, irq_out, cnt_rdata} !== '0) begin
      errors++;
      $display("[TB] FAIL rst_async: pending=%h overrun=%h enable=%h irq_out=%b count=%h expected all 0",
               pending, overrun, enable, irq_out, cnt_rdata);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    irq_in = 8'h04;
    tick();
    irq_in = '0;
    tick();
    tick();
    vectors++;
    if (pending !== 8'h04 || irq_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_cold: pending=%h irq_out=%b expected 04/0", pending, irq_out);
    end
    do_enable(8'h04);
    vectors++;
    if (irq_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_en0: irq_out=%b expected 0", irq_out);
    end
    tick();
    vectors++;
    if (irq_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_en1: irq_out=%b expected 1", irq_out);
    end
    // holdoff length was reset to 0, so a clear plus re-pulse gives one low cycle
    do_clear(8'h04);
    irq_in = 8'h04;
    tick();
    irq_in = '0;
    low = 0;
    while (irq_out === 1'b0 && low < 40) begin
      low++;
      tick();
    end
    vectors++;
    if (low != 1) begin
      errors++;
      $display("[TB] FAIL rst_holdoff: low cycles=%0d expected 1", low);
    end
  endtask

  // Directed test sequence
  initial begin
    rst_n = 1'b0;
    irq_in = '0;
    enable_wr = 1'b0;
    enable_wdata = '0;
    clear_wr = 1'b0;
    clear_wdata = '0;
    holdoff_wr = 1'b0;
    holdoff_wdata = '0;
    cnt_sel = '0;
    test_reset();
    test_single_pulse();
    test_disabled_source();
    test_clear_collision();
    test_saturation();
    test_holdoff();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
